ulpi_phy_responder: RTL and testbench

//  Synthesizable PHY-side ULPI endpoint; the counterpart of the ULPI link controller.

---
 rtl/ulpi_phy_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_ulpi_phy_responder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_phy_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ulpi_phy_responder
//  Purpose  : PHY-side ULPI endpoint. Owns DIR/NXT, serves register reads and
//             writes from a 64x8 register file, captures transmit packets and
//             injects RXCMD bytes and receive packets from a local source.
//  Revision : 1.0 - initial release
// ============================================================================
module ulpi_phy_responder #(
  parameter int          RESET_CYCLES = 8,
  parameter logic [15:0] VENDOR_ID    = 16'h0424,
  parameter logic [15:0] PRODUCT_ID   = 16'h0009,
  parameter int          NXT_THROTTLE = 0
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic [7:0] ULPI_DATA_I,
  output logic [7:0] ULPI_DATA_O,
  output logic       ULPI_DATA_OE,
  output logic       ULPI_DIR,
  output logic       ULPI_NXT,
  input  logic       ULPI_STP,
  input  logic [7:0] RXCMD_IN,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  input  logic       RX_LAST,
  output logic       RX_READY,
  output logic [7:0] TX_DATA,
  output logic       TX_STRB,
  output logic [3:0] TX_PID,
  output logic       TX_END
);

  localparam logic [5:0] c_FUN_CTRL = 6'h04;
  localparam logic [5:0] c_FUN_SET  = 6'h05;
  localparam logic [5:0] c_FUN_CLR  = 6'h06;
  localparam logic [7:0] c_RST_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] c_THR_LAST = 8'(NXT_THROTTLE - 1);

  typedef enum logic [4:0] {
    S_IDLE    = 5'd0,
    S_W_CMD   = 5'd1,
    S_W_DATA  = 5'd2,
    S_W_STP   = 5'd3,
    S_R_CMD   = 5'd4,
    S_R_TURN  = 5'd5,
    S_R_DATA  = 5'd6,
    S_R_TURN2 = 5'd7,
    S_X_DATA  = 5'd8,
    S_RX_TUP  = 5'd9,
    S_RX_CMD  = 5'd10,
    S_RX_DATA = 5'd11,
    S_RX_TDN  = 5'd12,
    S_C_TUP   = 5'd13,
    S_C_CMD   = 5'd14,
    S_C_TDN   = 5'd15,
    S_RST     = 5'd16
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] last_rx_q, last_rx_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;
  logic [7:0] thr_cnt_q, thr_cnt_d;
  logic       thr_gap_q, thr_gap_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_strb_q, tx_strb_d;
  logic [3:0] tx_pid_q, tx_pid_d;
  logic       tx_end_q, tx_end_d;

  logic [7:0] regs_q [64];

  logic [7:0] w_rd_data;
  logic [7:0] w_fc_new;
  logic [7:0] w_fc_wdata;
  logic       w_is_fc;
  logic       w_is_ro;
  logic       w_reg_we;
  logic       w_fc_we;
  logic       w_regs_clr;

  assign w_is_ro = (addr_q < 6'd4);
  assign w_is_fc = (addr_q == c_FUN_CTRL) || (addr_q == c_FUN_SET) || (addr_q == c_FUN_CLR);

  // Register read mux: IDs are constants, set/clear aliases read FUN_CTRL
  always_comb begin
    case (addr_q)
      6'h00:                w_rd_data = VENDOR_ID[7:0];
      6'h01:                w_rd_data = VENDOR_ID[15:8];
      6'h02:                w_rd_data = PRODUCT_ID[7:0];
      6'h03:                w_rd_data = PRODUCT_ID[15:8];
      c_FUN_SET, c_FUN_CLR: w_rd_data = regs_q[c_FUN_CTRL];
      default:              w_rd_data = regs_q[addr_q];
    endcase
  end

  // FUN_CTRL value that a committed write to 0x04/0x05/0x06 would produce
  always_comb begin
    case (addr_q)
      c_FUN_SET: w_fc_new = regs_q[c_FUN_CTRL] | wdata_q;
      c_FUN_CLR: w_fc_new = regs_q[c_FUN_CTRL] & ~wdata_q;
      default:   w_fc_new = wdata_q;
    endcase
  end

  // Next-state and bus output decode
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_rx_d    = last_rx_q;
    rst_cnt_d    = rst_cnt_q;
    thr_cnt_d    = thr_cnt_q;
    thr_gap_d    = 1'b0;
    tx_data_d    = tx_data_q;
    tx_strb_d    = 1'b0;
    tx_pid_d     = tx_pid_q;
    tx_end_d     = 1'b0;
    w_reg_we     = 1'b0;
    w_fc_we      = 1'b0;
    w_fc_wdata   = w_fc_new;
    w_regs_clr   = 1'b0;
    ULPI_DIR     = 1'b0;
    ULPI_DATA_OE = 1'b0;
    ULPI_NXT     = 1'b0;
    ULPI_DATA_O  = 8'h00;
    RX_READY     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Taking the bus for RX wins; any TXCMD on the bus this cycle is lost
        if (RX_VALID) begin
          state_d = S_RX_TUP;
        end else if (RXCMD_IN != last_rx_q) begin
          state_d = S_C_TUP;
        end else begin
          addr_d    = ULPI_DATA_I[5:0];
          thr_cnt_d = 8'd0;
          case (ULPI_DATA_I[7:6])
            2'b10: state_d = S_W_CMD;
            2'b11: state_d = S_R_CMD;
            2'b01: begin
              state_d  = S_X_DATA;
              tx_pid_d = ULPI_DATA_I[3:0];
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_W_CMD: begin
        ULPI_NXT = 1'b1;
        state_d  = S_W_DATA;
      end

      S_W_DATA: begin
        ULPI_NXT = 1'b1;
        wdata_d  = ULPI_DATA_I;
        state_d  = S_W_STP;
      end

      S_W_STP: begin
        state_d = S_IDLE;
        if (ULPI_STP) begin
          if (w_is_fc) begin
            w_fc_we = 1'b1;
            if (w_fc_new[5]) begin
              // Reset bit: clear everything, keep the rest of FUN_CTRL, drop bit5
              w_regs_clr = 1'b1;
              w_fc_wdata = w_fc_new & 8'hDF;
              last_rx_d  = 8'h00;
              rst_cnt_d  = 8'd0;
              state_d    = S_RST;
            end
          end else if (!w_is_ro) begin
            w_reg_we = 1'b1;
          end
        end
      end

      S_R_CMD: begin
        ULPI_NXT = 1'b1;
        state_d  = S_R_TURN;
      end

      S_R_TURN: begin
        ULPI_DIR = 1'b1;
        state_d  = S_R_DATA;
      end

      S_R_DATA: begin
        ULPI_DIR     = 1'b1;
        ULPI_DATA_OE = 1'b1;
        ULPI_DATA_O  = w_rd_data;
        state_d      = S_R_TURN2;
      end

      S_R_TURN2: begin
        state_d = S_IDLE;
      end

      S_X_DATA: begin
        ULPI_NXT = !thr_gap_q && !ULPI_STP;
        if (ULPI_STP) begin
          tx_end_d = 1'b1;
          state_d  = S_IDLE;
        end else if (!thr_gap_q) begin
          tx_strb_d = 1'b1;
          tx_data_d = ULPI_DATA_I;
          if (NXT_THROTTLE > 0) begin
            if (thr_cnt_q == c_THR_LAST) begin
              thr_cnt_d = 8'd0;
              thr_gap_d = 1'b1;
            end else begin
              thr_cnt_d = thr_cnt_q + 8'd1;
            end
          end
        end
      end

      S_RX_TUP: begin
        ULPI_DIR = 1'b1;
        state_d  = S_RX_CMD;
      end

      S_RX_CMD: begin
        ULPI_DIR     = 1'b1;
        ULPI_DATA_OE = 1'b1;
        ULPI_DATA_O  = RXCMD_IN;
        last_rx_d    = RXCMD_IN;
        state_d      = S_RX_DATA;
      end

      S_RX_DATA: begin
        ULPI_DIR     = 1'b1;
        ULPI_DATA_OE = 1'b1;
        if (RX_VALID) begin
          ULPI_NXT    = 1'b1;
          RX_READY    = 1'b1;
          ULPI_DATA_O = RX_DATA;
          if (RX_LAST) begin
            state_d = S_RX_TDN;
          end
        end else begin
          ULPI_DATA_O = RXCMD_IN;
        end
      end

      S_RX_TDN: begin
        state_d = S_IDLE;
      end

      S_C_TUP: begin
        ULPI_DIR = 1'b1;
        state_d  = S_C_CMD;
      end

      S_C_CMD: begin
        ULPI_DIR     = 1'b1;
        ULPI_DATA_OE = 1'b1;
        ULPI_DATA_O  = RXCMD_IN;
        last_rx_d    = RXCMD_IN;
        state_d      = S_C_TDN;
      end

      S_C_TDN: begin
        ULPI_DIR = 1'b1;
        state_d  = S_IDLE;
      end

      S_RST: begin
        ULPI_DIR = 1'b1;
        if (rst_cnt_q == c_RST_LAST) begin
          state_d = S_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and transmit-side state registers
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q   <= S_IDLE;
      addr_q    <= 6'd0;
      wdata_q   <= 8'h00;
      last_rx_q <= 8'h00;
      rst_cnt_q <= 8'd0;
      thr_cnt_q <= 8'd0;
      thr_gap_q <= 1'b0;
      tx_data_q <= 8'h00;
      tx_strb_q <= 1'b0;
      tx_pid_q  <= 4'h0;
      tx_end_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_rx_q <= last_rx_d;
      rst_cnt_q <= rst_cnt_d;
      thr_cnt_q <= thr_cnt_d;
      thr_gap_q <= thr_gap_d;
      tx_data_q <= tx_data_d;
      tx_strb_q <= tx_strb_d;
      tx_pid_q  <= tx_pid_d;
      tx_end_q  <= tx_end_d;
    end
  end

  // Register file; the FUN_CTRL update lands after a bulk clear
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      for (int i = 0; i < 64; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      if (w_regs_clr) begin
        for (int i = 0; i < 64; i++) begin
          regs_q[i] <= 8'h00;
        end
      end
      if (w_reg_we) begin
        regs_q[addr_q] <= wdata_q;
      end
      if (w_fc_we) begin
        regs_q[c_FUN_CTRL] <= w_fc_wdata;
      end
    end
  end

  assign TX_DATA = tx_data_q;
  assign TX_STRB = tx_strb_q;
  assign TX_PID  = tx_pid_q;
  assign TX_END  = tx_end_q;

endmodule
`default_nettype wire

// File: tb/tb_ulpi_phy_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ulpi_phy_responder
//  Purpose  : Self-checking bench for ulpi_phy_responder acting as a ULPI link,
//             with a register/RXCMD reference model. A second instance runs
//             with NXT throttling enabled for transmit checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ulpi_phy_responder;

  localparam int          RESET_CYCLES = 8;
  localparam logic [15:0] VID          = 16'h0424;
  localparam logic [15:0] PID          = 16'h0009;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] link_d, t_link_d;
  logic       link_stp, t_link_stp;
  logic [7:0] rxcmd_in, rx_data;
  logic       rx_valid, rx_last;

  logic [7:0] data_o, tx_data, t_data_o, t_tx_data;
  logic       oe, dir, nxt, rx_ready, tx_strb, tx_end;
  logic       t_oe, t_dir, t_nxt, t_rx_ready, t_tx_strb, t_tx_end;
  logic [3:0] tx_pid, t_tx_pid;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [64];
  logic [7:0] last_rx;

  always #5 clk = ~clk;

  ulpi_phy_responder #(
    .RESET_CYCLES(RESET_CYCLES), .VENDOR_ID(VID), .PRODUCT_ID(PID), .NXT_THROTTLE(0)
  ) u_dut (
    .CLK_60M(clk), .NRST_A_USB(rst_n),
    .ULPI_DATA_I(link_d), .ULPI_DATA_O(data_o), .ULPI_DATA_OE(oe),
    .ULPI_DIR(dir), .ULPI_NXT(nxt), .ULPI_STP(link_stp),
    .RXCMD_IN(rxcmd_in), .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_LAST(rx_last),
    .RX_READY(rx_ready), .TX_DATA(tx_data), .TX_STRB(tx_strb), .TX_PID(tx_pid), .TX_END(tx_end)
  );

  ulpi_phy_responder #(
    .RESET_CYCLES(RESET_CYCLES), .VENDOR_ID(VID), .PRODUCT_ID(PID), .NXT_THROTTLE(2)
  ) u_thr (
    .CLK_60M(clk), .NRST_A_USB(rst_n),
    .ULPI_DATA_I(t_link_d), .ULPI_DATA_O(t_data_o), .ULPI_DATA_OE(t_oe),
    .ULPI_DIR(t_dir), .ULPI_NXT(t_nxt), .ULPI_STP(t_link_stp),
    .RXCMD_IN(8'h00), .RX_DATA(8'h00), .RX_VALID(1'b0), .RX_LAST(1'b0),
    .RX_READY(t_rx_ready), .TX_DATA(t_tx_data), .TX_STRB(t_tx_strb), .TX_PID(t_tx_pid), .TX_END(t_tx_end)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int sel, input logic [7:0] d, input logic s);
    if (sel == 0) begin
      link_d = d; link_stp = s;
    end else begin
      t_link_d = d; t_link_stp = s;
    end
    #1;
  endtask

  function automatic logic f_nxt(input int sel);    return (sel != 0) ? t_nxt : nxt;         endfunction
  function automatic logic f_strb(input int sel);   return (sel != 0) ? t_tx_strb : tx_strb; endfunction
  function automatic logic f_end(input int sel);    return (sel != 0) ? t_tx_end : tx_end;   endfunction
  function automatic logic [7:0] f_txd(input int sel); return (sel != 0) ? t_tx_data : tx_data; endfunction
  function automatic logic [3:0] f_pid(input int sel); return (sel != 0) ? t_tx_pid : tx_pid;   endfunction

  // Reference register map
  function automatic logic [7:0] mread(input logic [5:0] a);
    case (a)
      6'h00:        return VID[7:0];
      6'h01:        return VID[15:8];
      6'h02:        return PID[7:0];
      6'h03:        return PID[15:8];
      6'h05, 6'h06: return mem[4];
      default:      return mem[a];
    endcase
  endfunction

  task automatic mclear();
    for (int j = 0; j < 64; j++) mem[j] = 8'h00;
    last_rx = 8'h00;
  endtask

  task automatic mwrite(input logic [5:0] a, input logic [7:0] d, output bit rst);
    logic [7:0] fc;
    rst = 1'b0;
    if (a < 6'd4) return;
    if (a >= 6'd4 && a <= 6'd6) begin
      if (a == 6'd4)      fc = d;
      else if (a == 6'd5) fc = mem[4] | d;
      else                fc = mem[4] & ~d;
      if (fc[5]) begin
        mclear();
        mem[4] = fc & 8'hDF;
        rst = 1'b1;
      end else begin
        mem[4] = fc;
      end
    end else begin
      mem[a] = d;
    end
  endtask

  task automatic regw(input logic [5:0] a, input logic [7:0] d, input bit commit);
    bit rst_exp;
    drv(0, {2'b10, a}, 1'b0);
    chk("regw_idle_dir", dir, 1'b0);
    tick();
    chk("regw_cmd_nxt", nxt, 1'b1);
    tick();
    drv(0, d, 1'b0);
    chk("regw_data_nxt", nxt, 1'b1);
    tick();
    drv(0, 8'h00, commit);
    chk("regw_stp_nxt", nxt, 1'b0);
    tick();
    drv(0, 8'h00, 1'b0);
    rst_exp = 1'b0;
    if (commit) mwrite(a, d, rst_exp);
    if (rst_exp) begin
      for (int i = 0; i < RESET_CYCLES; i++) begin
        chk("funrst_dir", dir, 1'b1);
        chk("funrst_oe", oe, 1'b0);
        tick();
      end
    end
    chk("regw_end_dir", dir, 1'b0);
  endtask

  task automatic regr(input logic [5:0] a);
    drv(0, {2'b11, a}, 1'b0);
    tick();
    chk("regr_cmd_nxt", nxt, 1'b1);
    chk("regr_cmd_dir", dir, 1'b0);
    tick();
    drv(0, 8'h00, 1'b0);
    chk("regr_turn_dir", dir, 1'b1);
    chk("regr_turn_oe", oe, 1'b0);
    tick();
    chk("regr_data_oe", {dir, oe}, 2'b11);
    chk("regr_data", data_o, mread(a));
    tick();
    chk("regr_turn2_dir", dir, 1'b0);
    tick();
  endtask

  task automatic xmit(input int sel, input logic [3:0] pid, input logic [7:0] b[$], input int thr);
    int         i = 0;
    int         cnt = 0;
    bit         gap = 1'b0;
    bit         prev_cap = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    drv(sel, {4'b0100, pid}, 1'b0);
    tick();
    while (i < b.size()) begin
      drv(sel, b[i], 1'b0);
      chk("xmit_nxt", f_nxt(sel), !gap);
      chk("xmit_strb", f_strb(sel), prev_cap);
      if (prev_cap) chk("xmit_data", f_txd(sel), prev_byte);
      prev_cap = !gap;
      if (!gap) begin
        prev_byte = b[i];
        i++;
        cnt++;
        gap = (thr > 0) && (cnt % thr == 0);
      end else begin
        gap = 1'b0;
      end
      tick();
    end
    drv(sel, 8'h00, 1'b1);
    chk("xmit_stp_nxt", f_nxt(sel), 1'b0);
    chk("xmit_strb", f_strb(sel), prev_cap);
    if (prev_cap) chk("xmit_data", f_txd(sel), prev_byte);
    tick();
    drv(sel, 8'h00, 1'b0);
    chk("xmit_end", f_end(sel), 1'b1);
    chk("xmit_end_strb", f_strb(sel), 1'b0);
    chk("xmit_pid", f_pid(sel), pid);
    chk("xmit_end_nxt", f_nxt(sel), 1'b0);
    tick();
    chk("xmit_end_pulse", f_end(sel), 1'b0);
  endtask

  task automatic rxcmd_report(input logic [7:0] v, input bit with_txcmd);
    rxcmd_in = v;
    drv(0, with_txcmd ? 8'h87 : 8'h00, 1'b0);
    chk("rpt_idle_dir", dir, 1'b0);
    tick();
    drv(0, 8'h00, 1'b0);
    chk("rpt_tup", {dir, oe, nxt}, 3'b100);
    tick();
    chk("rpt_cmd", {dir, oe, nxt}, 3'b110);
    chk("rpt_data", data_o, v);
    tick();
    chk("rpt_tdn", {dir, oe}, 2'b10);
    tick();
    chk("rpt_done", {dir, nxt}, 2'b00);
    last_rx = v;
  endtask

  task automatic rx_pkt(input logic [7:0] b[$], input int stall_pct);
    int i = 0;
    rx_valid = 1'b1; rx_data = b[0]; rx_last = (b.size() == 1);
    #1;
    chk("rx_idle", {dir, rx_ready}, 2'b00);
    tick();
    chk("rx_tup", {dir, oe, nxt, rx_ready}, 4'b1000);
    tick();
    chk("rx_cmd", {dir, oe, nxt, rx_ready}, 4'b1100);
    chk("rx_cmd_data", data_o, rxcmd_in);
    last_rx = rxcmd_in;
    tick();
    while (i < b.size()) begin
      if ($urandom_range(99) < stall_pct) begin
        rx_valid = 1'b0;
        #1;
        chk("rx_stall", {dir, oe, nxt, rx_ready}, 4'b1100);
        chk("rx_stall_data", data_o, rxcmd_in);
      end else begin
        rx_valid = 1'b1; rx_data = b[i]; rx_last = (i == b.size() - 1);
        #1;
        chk("rx_byte", {dir, oe, nxt, rx_ready}, 4'b1111);
        chk("rx_byte_data", data_o, b[i]);
        i++;
      end
      tick();
    end
    rx_valid = 1'b0; rx_last = 1'b0;
    #1;
    chk("rx_tdn", {dir, oe, rx_ready}, 3'b000);
    tick();
  endtask

  initial begin
    logic [7:0] q[$];
    logic [5:0] a;
    logic [7:0] d;
    bit         c;

    rst_n = 1'b0;
    link_d = 8'h00; link_stp = 1'b0; t_link_d = 8'h00; t_link_stp = 1'b0;
    rxcmd_in = 8'h00; rx_data = 8'h00; rx_valid = 1'b0; rx_last = 1'b0;
    mclear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", {dir, nxt, oe, rx_ready}, 4'b0000);
    chk("rst_data_o", data_o, 8'h00);
    chk("rst_tx", {tx_strb, tx_end, tx_pid, tx_data}, 14'h0);
    rst_n = 1'b1;
    tick();

    // Basic write/read, aborted write, read-only IDs
    regw(6'h07, 8'h07, 1'b1);
    regr(6'h07);
    regw(6'h07, 8'h99, 1'b0);
    regr(6'h07);
    regr(6'h00);
    regr(6'h01);
    regr(6'h02);
    regr(6'h03);
    regw(6'h01, 8'hFF, 1'b1);
    regr(6'h01);

    // FUN_CTRL direct, set and clear aliases
    regw(6'h04, 8'h41, 1'b1);
    regw(6'h05, 8'h02, 1'b1);
    regr(6'h04);
    regw(6'h06, 8'h01, 1'b1);
    regr(6'h04);

    // Random register traffic
    for (int k = 0; k < 16; k++) begin
      a = 6'($urandom_range(63));
      d = 8'($urandom);
      c = ($urandom_range(3) != 0);
      if (a == 6'd4 || a == 6'd5) d[5] = 1'b0;
      regw(a, d, c);
      a = 6'($urandom_range(63));
      if (a == 6'd5 || a == 6'd6) a = 6'd7;
      regr(a);
    end

    // Transmit packets, unthrottled then throttled
    q = {};
    for (int k = 0; k < 6; k++) q.push_back(8'(8'h10 + k));
    xmit(0, 4'h3, q, 0);
    xmit(1, 4'h3, q, 2);
    for (int k = 0; k < 3; k++) begin
      q = {};
      for (int j = 0; j <= $urandom_range(7); j++) q.push_back(8'($urandom));
      xmit(0, 4'($urandom), q, 0);
      xmit(1, 4'($urandom), q, 2);
    end

    // RXCMD reports; a TXCMD presented as DIR rises is dropped
    rxcmd_report(8'h55, 1'b1);
    regr(6'h07);
    rxcmd_report(8'h3C, 1'b0);

    // Receive packets
    q = {8'hA5, 8'h5A};
    rx_pkt(q, 0);
    for (int k = 0; k < 3; k++) begin
      q = {};
      for (int j = 0; j <= $urandom_range(6); j++) q.push_back(8'($urandom));
      rx_pkt(q, 30);
    end
    rxcmd_report(8'h00, 1'b0);

    // FUN_CTRL reset
    regw(6'h09, 8'hC3, 1'b1);
    regw(6'h04, 8'h60, 1'b1);
    regr(6'h04);
    regr(6'h09);

    // Asynchronous reset in the middle of a transmit
    regw(6'h07, 8'h5C, 1'b1);
    regr(6'h07);
    drv(0, 8'h4A, 1'b0);
    tick();
    drv(0, 8'h77, 1'b0);
    chk("arst_pre_nxt", nxt, 1'b1);
    tick();
    chk("arst_pre_strb", tx_strb, 1'b1);
    chk("arst_pre_pid", tx_pid, 4'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bus", {dir, nxt, oe}, 3'b000);
    chk("arst_tx", {tx_strb, tx_end, tx_pid, tx_data}, 14'h0);
    drv(0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mclear();
    tick();
    regr(6'h07);
    regr(6'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
